// File: rtl/banked_ram.sv
// ============================================================================
// banked_ram
// ----------------------------------------------------------------------------
// Parametrised, banked, synchronous-read data memory with a valid/ready
// request port, a registered read response and a hardware clear sequencer
// that zeroes every word after reset (optional) or on command.
//
// Parameters:
//   WIDTH          data word width in bits
//   ADDR_W         word-address width, total depth 2^ADDR_W
//   BANK_BITS      bank-select bits taken from the address MSBs (0..ADDR_W-1)
//   CLEAR_ON_RESET 1 = run the clear sweep after reset, 0 = go straight to READY
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        request to re-run the clear sweep, sampled only in READY
//   req_valid  request present
//   req_ready  block accepts a request this cycle
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   rsp_valid  one-cycle pulse, read data valid
//   rsp_rdata  read data, holds its last value while rsp_valid is 0
//   busy       clear sweep in progress (or still in RESET)
// ============================================================================
module banked_ram #(
    parameter int WIDTH          = 16,
    parameter int ADDR_W         = 14,
    parameter int BANK_BITS      = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              busy
);

    localparam int IDX_W  = ADDR_W - BANK_BITS;
    localparam int BANKS  = 1 << BANK_BITS;
    localparam int DEPTH  = 1 << IDX_W;
    // Keep the bank-select vector at least one bit wide so BANK_BITS = 0
    // (single bank) still elaborates; the shift below then yields 0.
    localparam int BSEL_W = (BANK_BITS > 0) ? BANK_BITS : 1;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  cnt;
    logic [WIDTH-1:0]  mem [BANKS][DEPTH];

    logic [BSEL_W-1:0] bank_sel;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              wr_en;
    logic              rd_en;

    // Bank bits are the address MSBs; the remaining low bits index the bank.
    assign bank_sel = BSEL_W'(req_addr >> IDX_W);
    assign idx      = req_addr[IDX_W-1:0];

    // clr takes priority over a simultaneous request by masking ready.
    assign req_ready = (state == ST_READY) && !clr;
    assign busy      = (state == ST_CLEAR) || (state == ST_RESET);
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_we;
    assign rd_en     = accept && !req_we;

    // State register and sweep counter. The counter only runs while
    // clearing and sits at 0 otherwise, so every sweep starts at index 0
    // and wraps naturally after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RESET;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) begin
                cnt <= cnt + IDX_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET: begin
                state_nxt = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            end
            ST_CLEAR: begin
                if (cnt == {IDX_W{1'b1}}) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_nxt = ST_CLEAR;
                end
            end
            default: begin
                state_nxt = ST_RESET;
            end
        endcase
    end

    // Storage array. No reset here on purpose: contents survive rst_n and
    // are only zeroed by the sweep, which writes index cnt in every bank at
    // once. Outside the sweep only the addressed bank is written.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (state == ST_CLEAR) begin
                mem[b][cnt] <= '0;
            end else if (wr_en && (bank_sel == BSEL_W'(b))) begin
                mem[b][idx] <= req_wdata;
            end
        end
    end

    // Registered read response. Reset drops any pending response and clears
    // the data register; otherwise rsp_rdata only changes on a read accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rd_en;
            if (rd_en) begin
                rsp_rdata <= mem[bank_sel][idx];
            end
        end
    end

endmodule

// File: tb/tb_banked_ram.sv
// ============================================================================
// tb_banked_ram
// ----------------------------------------------------------------------------
// Directed testbench for banked_ram. Instance "dut" is a small 16-word,
// 4-bank memory with the clear sweep enabled; instance "dut_nc" uses the
// default geometry with the post-reset sweep disabled. Inputs are driven on
// the falling edge and outputs are sampled on the falling edge that follows
// the rising edge of interest.
// ============================================================================
module tb_banked_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance: ADDR_W=4, BANK_BITS=2, CLEAR_ON_RESET=1
    logic        rst_n;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;

    // Default-geometry instance without the post-reset sweep
    logic        nc_rst_n;
    logic        nc_clr;
    logic        nc_req_valid;
    logic        nc_req_ready;
    logic        nc_req_we;
    logic [13:0] nc_req_addr;
    logic [15:0] nc_req_wdata;
    logic        nc_rsp_valid;
    logic [15:0] nc_rsp_rdata;
    logic        nc_busy;

    int checks = 0;
    int errors = 0;

    banked_ram #(
        .WIDTH(16), .ADDR_W(4), .BANK_BITS(2), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
    );

    banked_ram #(
        .WIDTH(16), .ADDR_W(14), .BANK_BITS(2), .CLEAR_ON_RESET(0)
    ) dut_nc (
        .clk(clk), .rst_n(nc_rst_n), .clr(nc_clr),
        .req_valid(nc_req_valid), .req_ready(nc_req_ready), .req_we(nc_req_we),
        .req_addr(nc_req_addr), .req_wdata(nc_req_wdata),
        .rsp_valid(nc_rsp_valid), .rsp_rdata(nc_rsp_rdata), .busy(nc_busy)
    );

    // Reset values, then 5 busy edges (1 RESET + 4 CLEAR) before READY,
    // then every one of the 16 words reads back as zero, one per cycle.
    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy got %b expected 1", busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rsp_rdata got %h expected 0000", rsp_rdata); end
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            checks++; if (busy !== 1'(e < 5)) begin errors++; $display("[TB] FAIL sweep_busy edge %0d got %b expected %b", e, busy, 1'(e < 5)); end
            checks++; if (req_ready !== 1'(e >= 5)) begin errors++; $display("[TB] FAIL sweep_ready edge %0d got %b expected %b", e, req_ready, 1'(e >= 5)); end
        end
        for (int a = 0; a <= 16; a++) begin
            if (a > 0) begin
                checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_read_valid addr %0d got %b expected 1", a - 1, rsp_valid); end
                checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL zero_read_data addr %0d got %h expected 0000", a - 1, rsp_rdata); end
            end
            if (a < 16) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(a);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_read_pulse_end got %b expected 0", rsp_valid); end
    endtask

    // Writes land only in their own bank; back-to-back reads across banks.
    task automatic test_bank_isolation();
        logic [3:0]  waddr [3] = '{4'h3, 4'h7, 4'hF};
        logic [15:0] wdata [3] = '{16'hA5A5, 16'h1234, 16'hFFFF};
        logic [3:0]  raddr [4] = '{4'h3, 4'h7, 4'hB, 4'hF};
        logic [15:0] rexp  [4] = '{16'hA5A5, 16'h1234, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = waddr[i]; req_wdata = wdata[i];
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL write_no_rsp %0d got %b expected 0", i, rsp_valid); end
        end
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bank_read_valid %0d got %b expected 1", i - 1, rsp_valid); end
                checks++; if (rsp_rdata !== rexp[i-1]) begin errors++; $display("[TB] FAIL bank_read_data addr %h got %h expected %h", raddr[i-1], rsp_rdata, rexp[i-1]); end
            end
            if (i < 4) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = raddr[i];
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Read on the cycle right after a write sees the new data, which then
    // holds after rsp_valid drops.
    task automatic test_write_then_read();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h9; req_wdata = 16'hBEEF;
        @(negedge clk);
        req_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL wtr_valid got %b expected 1", rsp_valid); end
        checks++; if (rsp_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL wtr_data got %h expected beef", rsp_rdata); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wtr_pulse_end got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL wtr_hold got %h expected beef", rsp_rdata); end
    endtask

    // clr and a read together: clr wins, sweep lasts 4 cycles, data zeroed.
    task automatic test_clr_collision();
        clr = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h9;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL clr_ready_comb got %b expected 0", req_ready); end
        @(negedge clk);
        clr = 1'b0; req_valid = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            checks++; if (busy !== 1'(i < 4)) begin errors++; $display("[TB] FAIL clr_busy cycle %0d got %b expected %b", i, busy, 1'(i < 4)); end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_no_accept cycle %0d got %b expected 0", i, rsp_valid); end
            if (i < 4) @(negedge clk);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h9;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL clr_read_valid got %b expected 1", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL clr_read_data got %h expected 0000", rsp_rdata); end
        @(negedge clk);
    endtask

    // Reset right after a read is accepted drops the response; sweep reruns.
    task automatic test_mid_read_reset();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h5; req_wdata = 16'h1111;
        @(negedge clk);
        req_we = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_data got %h expected 0000", rsp_rdata); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy got %b expected 1", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            checks++; if (req_ready !== 1'(e >= 5)) begin errors++; $display("[TB] FAIL midrst_sweep edge %0d got %b expected %b", e, req_ready, 1'(e >= 5)); end
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h5;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_read_valid got %b expected 1", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_read_data got %h expected 0000", rsp_rdata); end
        @(negedge clk);
    endtask

    // Without the post-reset sweep, contents survive reset and READY comes
    // on the first edge after release.
    task automatic test_no_clear();
        nc_rst_n = 1'b1;
        @(negedge clk);
        checks++; if (nc_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL nc_ready_first got %b expected 1", nc_req_ready); end
        checks++; if (nc_busy !== 1'b0) begin errors++; $display("[TB] FAIL nc_busy_first got %b expected 0", nc_busy); end
        nc_req_valid = 1'b1; nc_req_we = 1'b1; nc_req_addr = 14'h3FFF; nc_req_wdata = 16'h5555;
        @(negedge clk);
        nc_req_valid = 1'b0;
        nc_rst_n = 1'b0;
        #1;
        checks++; if (nc_busy !== 1'b1) begin errors++; $display("[TB] FAIL nc_rst_busy got %b expected 1", nc_busy); end
        @(negedge clk);
        nc_rst_n = 1'b1;
        #1;
        checks++; if (nc_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL nc_ready_before_edge got %b expected 0", nc_req_ready); end
        @(negedge clk);
        checks++; if (nc_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL nc_ready_after_pulse got %b expected 1", nc_req_ready); end
        nc_req_valid = 1'b1; nc_req_we = 1'b0; nc_req_addr = 14'h3FFF;
        @(negedge clk);
        nc_req_valid = 1'b0;
        checks++; if (nc_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL nc_read_valid got %b expected 1", nc_rsp_valid); end
        checks++; if (nc_rsp_rdata !== 16'h5555) begin errors++; $display("[TB] FAIL nc_read_data got %h expected 5555", nc_rsp_rdata); end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0;
        nc_rst_n = 1'b0; nc_clr = 1'b0; nc_req_valid = 1'b0; nc_req_we = 1'b0;
        nc_req_addr = '0; nc_req_wdata = '0;
        @(negedge clk);
        test_reset();
        test_bank_isolation();
        test_write_then_read();
        test_clr_collision();
        test_mid_read_reset();
        test_no_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
